cdb_arbiter: RTL

Collects `complete_valid`/`complete_data` results from all functional units (ALUs, multiplier, load/store, branch) and serialises them onto the single common data bus (CDB) feeding the scoreboard writeback and register file. FUs present a result for exactly one cycle and have no ready input, so every result is captured into a per-FU FIFO. A round-robin arbiter drains one entry per cycle onto a registered CDB output. Per-FU stall outputs tell the scoreboard issue logic to stop issuing to a FU whose buffer is close to full.

---
 rtl/cdb_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers one-cycle FU completion pulses in per-FU
// FIFOs and drains them round-robin, one packet per cycle, onto a registered CDB.

package rv32i_types;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } cdb_t;
endpackage

module cdb_arbiter #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_FU-1:0]         fu_complete_valid,
  input  rv32i_types::cdb_t         fu_complete_data [NUM_FU],
  output logic [NUM_FU-1:0]         fu_stall,
  output logic                      cdb_valid,
  output rv32i_types::cdb_t         cdb_data,
  output logic [$clog2(NUM_FU)-1:0] cdb_grant_fu,
  output logic                      overflow
);
  import rv32i_types::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = $clog2(NUM_FU);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [GW-1:0] LAST_FU  = GW'(NUM_FU - 1);

  // FIFO storage and bookkeeping
  cdb_t                     mem_q [NUM_FU][DEPTH];
  logic [NUM_FU-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_FU-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_FU-1:0][CW-1:0] count_q, count_d;

  // Arbitration and output state
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic          cdb_valid_q, cdb_valid_d;
  cdb_t          cdb_data_q, cdb_data_d;
  logic [GW-1:0] grant_q, grant_d;
  logic          overflow_q, overflow_d;

  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] drop;
  logic              grant_valid;
  logic [GW-1:0]     grant_idx;
  logic [GW-1:0]     cand;

  // FIFO status and stall flags, from registered counts only
  always_comb begin
    nonempty = '0;
    full     = '0;
    fu_stall = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      nonempty[i] = (count_q[i] != '0);
      full[i]     = (count_q[i] == FULL_CNT);
      // Leaves room for one issue already in flight when stall rises.
      fu_stall[i] = ((FULL_CNT - count_q[i]) <= CW'(1));
    end
  end

  // Round-robin select: first non-empty FIFO at or after rr_ptr, wrapping
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      cand = GW'((32'(rr_ptr_q) + k) % NUM_FU);
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Push/pop qualification; a pop frees the slot for a same-cycle push
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      pop[i]  = grant_valid && (grant_idx == GW'(i));
      push[i] = fu_complete_valid[i] && (!full[i] || pop[i]);
      drop[i] = fu_complete_valid[i] && full[i] && !pop[i];
    end
  end

  // FIFO pointer and count next-state; pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  // CDB, round-robin pointer and sticky overflow next-state
  always_comb begin
    cdb_valid_d = grant_valid;
    cdb_data_d  = '0;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_valid) begin
      cdb_data_d       = mem_q[grant_idx][rd_ptr_q[grant_idx]];
      cdb_data_d.valid = 1'b1;
      grant_d          = grant_idx;
      rr_ptr_d         = (grant_idx == LAST_FU) ? '0 : grant_idx + GW'(1);
    end
    overflow_d = overflow_q | (|drop);
  end

  // State registers; reset beats flush, flush keeps rr_ptr/overflow/grant
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      grant_q     <= '0;
      overflow_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      grant_q     <= grant_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO payload storage; no reset needed, validity tracked by counts
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (push[i]) begin
          mem_q[i][wr_ptr_q[i]] <= fu_complete_data[i];
        end
      end
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_grant_fu = grant_q;
  assign overflow     = overflow_q;

endmodule
